// File: rtl/sd_dma_wr.sv
// rtl/sd_dma_wr.sv - SD card single-block DMA writer: streams SRAM bytes to DAT[3:0], appends per-line CRC16, checks the card token and busy.
// The state machine advances only on SD clock boundaries (phase==3); output data changes at phase==0.
module sd_dma_wr #(
  parameter int BLOCK_BYTES  = 512,
  parameter int BUSY_TIMEOUT = 16'hFFFF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SD_DMA_EN,
  inout  wire        SD_CLK,
  output logic [3:0] SD_DAT_OUT,
  output logic       SD_DAT_OE,
  input  logic [3:0] SD_DAT_IN,
  input  logic [7:0] SD_DMA_SRAM_DATA,
  output logic       SD_DMA_SRAM_RE,
  output logic       SD_DMA_NEXTADDR,
  output logic       SD_DMA_STATUS,
  output logic [1:0] SD_DMA_ERR
);

  localparam int DATA_CLKS = 2 * BLOCK_BYTES;
  localparam int MAXC      = (DATA_CLKS > BUSY_TIMEOUT) ? DATA_CLKS : BUSY_TIMEOUT;
  localparam int CW        = $clog2(MAXC + 1) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CRC   = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;
  localparam logic [2:0] S_TOKEN = 3'd6;
  localparam logic [2:0] S_BUSY  = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             sd_clk_q, sd_clk_d;
  logic [1:0]       sync_q, sync_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       dat_q, dat_d;
  logic [7:0]       pre_q, pre_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0][15:0] crc_q, crc_d;
  logic             nextaddr_q, nextaddr_d;
  logic [1:0]       err_q, err_d;
  logic             samp_q, samp_d;
  logic             tok_started_q, tok_started_d;
  logic [1:0]       tok_sr_q, tok_sr_d;
  logic             start;
  logic [2:0]       unused_dat_in;

  assign unused_dat_in = SD_DAT_IN[3:1];

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign start = sync_q[0] & ~sync_q[1];

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    sd_clk_d      = sd_clk_q;
    sync_d        = {sync_q[0], SD_DMA_EN};
    cnt_d         = cnt_q;
    dat_d         = dat_q;
    pre_d         = pre_q;
    shift_d       = shift_q;
    crc_d         = crc_q;
    nextaddr_d    = 1'b0;
    err_d         = err_q;
    samp_d        = samp_q;
    tok_started_d = tok_started_q;
    tok_sr_d      = tok_sr_q;
    if (state_q == S_IDLE) begin
      sd_clk_d = 1'b0;
      if (start) begin
        state_d       = S_PRE;
        phase_d       = 2'd0;
        cnt_d         = '0;
        err_d         = 2'b00;
        crc_d         = '0;
        tok_started_d = 1'b0;
      end
    end else begin
      phase_d  = phase_q + 2'd1;
      sd_clk_d = phase_q[1];
      if (phase_q == 2'd0) begin
        case (state_q)
          S_PRE: begin
            dat_d = 4'hF;
            if (cnt_q == CW'(1)) pre_d = SD_DMA_SRAM_DATA;
          end
          S_START: dat_d = 4'h0;
          S_DATA: begin
            // High nibble hands the prefetched byte to the shifter and advances the address;
            // the low nibble slot refills the prefetch from the new address.
            if (!cnt_q[0]) begin
              shift_d    = pre_q;
              dat_d      = pre_q[7:4];
              nextaddr_d = 1'b1;
            end else begin
              dat_d = shift_q[3:0];
              pre_d = SD_DMA_SRAM_DATA;
            end
            for (int i = 0; i < 4; i++) crc_d[i] = crc16_step(crc_q[i], dat_d[i]);
          end
          S_CRC: begin
            for (int i = 0; i < 4; i++) begin
              dat_d[i] = crc_q[i][15];
              crc_d[i] = {crc_q[i][14:0], 1'b0};
            end
          end
          S_END:   dat_d = 4'hF;
          default: ;
        endcase
      end
      if (phase_q == 2'd2) samp_d = SD_DAT_IN[0];
      if (phase_q == 2'd3) begin
        cnt_d = cnt_q + CW'(1);
        case (state_q)
          S_PRE:   if (cnt_q == CW'(1)) begin state_d = S_START; cnt_d = '0; end
          S_START: begin state_d = S_DATA; cnt_d = '0; end
          S_DATA:  if (cnt_q == CW'(DATA_CLKS - 1)) begin state_d = S_CRC; cnt_d = '0; end
          S_CRC:   if (cnt_q == CW'(15)) begin state_d = S_END; cnt_d = '0; end
          S_END: begin
            state_d       = S_TOKEN;
            cnt_d         = '0;
            tok_started_d = 1'b0;
          end
          S_TOKEN: begin
            if (!tok_started_q) begin
              if (!samp_q) begin
                tok_started_d = 1'b1;
                cnt_d         = '0;
              end else if (cnt_q == CW'(15)) begin
                err_d[1] = 1'b1;
                state_d  = S_IDLE;
              end
            end else begin
              // Three status bits, then the end bit is consumed so it is not mistaken for busy release.
              tok_sr_d = {tok_sr_q[0], samp_q};
              if (cnt_q == CW'(2) && {tok_sr_q, samp_q} != 3'b010) begin
                err_d[0] = 1'b1;
                state_d  = S_IDLE;
              end else if (cnt_q == CW'(3)) begin
                state_d = S_BUSY;
                cnt_d   = '0;
              end
            end
          end
          S_BUSY: begin
            if (samp_q) begin
              state_d = S_IDLE;
            end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
              err_d[1] = 1'b1;
              state_d  = S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      phase_q       <= 2'd0;
      sd_clk_q      <= 1'b0;
      sync_q        <= 2'b00;
      cnt_q         <= '0;
      dat_q         <= 4'hF;
      pre_q         <= 8'h00;
      shift_q       <= 8'h00;
      crc_q         <= '0;
      nextaddr_q    <= 1'b0;
      err_q         <= 2'b00;
      samp_q        <= 1'b0;
      tok_started_q <= 1'b0;
      tok_sr_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      sd_clk_q      <= sd_clk_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      dat_q         <= dat_d;
      pre_q         <= pre_d;
      shift_q       <= shift_d;
      crc_q         <= crc_d;
      nextaddr_q    <= nextaddr_d;
      err_q         <= err_d;
      samp_q        <= samp_d;
      tok_started_q <= tok_started_d;
      tok_sr_q      <= tok_sr_d;
    end
  end

  assign SD_DMA_STATUS   = (state_q != S_IDLE);
  assign SD_DAT_OE       = (state_q == S_PRE) || (state_q == S_START) || (state_q == S_DATA) ||
                           (state_q == S_CRC) || (state_q == S_END);
  assign SD_DMA_SRAM_RE  = ~SD_DAT_OE;
  assign SD_DAT_OUT      = dat_q;
  assign SD_DMA_NEXTADDR = nextaddr_q;
  assign SD_DMA_ERR      = err_q;
  assign SD_CLK          = SD_DMA_STATUS ? sd_clk_q : 1'bz;

endmodule

// File: tb/tb_sd_dma_wr.sv
// tb/tb_sd_dma_wr.sv - table-driven and randomized bench for sd_dma_wr with SRAM and SD card models.
module tb_sd_dma_wr;

  logic       clk;
  logic       rst_n;
  logic       en;
  wire        sd_clk_w;
  logic [3:0] dat_out;
  logic       oe;
  logic [3:0] dat_in;
  logic [7:0] sram_data;
  logic       re;
  logic       nxt;
  logic       status;
  logic [1:0] err;

  sd_dma_wr #(.BLOCK_BYTES(512), .BUSY_TIMEOUT(100)) dut (
    .CLK(clk), .RST_N(rst_n), .SD_DMA_EN(en), .SD_CLK(sd_clk_w),
    .SD_DAT_OUT(dat_out), .SD_DAT_OE(oe), .SD_DAT_IN(dat_in),
    .SD_DMA_SRAM_DATA(sram_data), .SD_DMA_SRAM_RE(re), .SD_DMA_NEXTADDR(nxt),
    .SD_DMA_STATUS(status), .SD_DMA_ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    bit         no_tok;
    logic [2:0] tok;
    int         busy;
    bit         tail;
    bit         retrig;
    logic [1:0] exp_err;
    int         exp_slots;
  } vec_t;

  int         n_vec = 0;
  int         n_mis = 0;
  logic [7:0] mem [1024];
  logic [15:0] addr;
  int         pulses;
  int         slots;
  logic [3:0] cap_q [$];
  logic [3:0] exp_q [$];
  bit         resp_q [$];
  bit         card_tail;
  logic       sd_prev;
  vec_t       tbl [8];

  assign sram_data = mem[addr[9:0]];

  // Card side: sample at SD_CLK rise while driven, answer on SD_CLK fall while released.
  always @(negedge clk) begin
    if (sd_clk_w === 1'b1 && sd_prev === 1'b0 && oe) cap_q.push_back(dat_out);
    if (sd_clk_w === 1'b0 && sd_prev === 1'b1 && !oe && status) begin
      slots++;
      if (resp_q.size() > 0) dat_in = {3'b111, resp_q.pop_front()};
      else dat_in = {3'b111, card_tail};
    end
    if (nxt) begin
      pulses++;
      addr++;
    end
    sd_prev = sd_clk_w;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input bit msg [$]);
    logic [16:0] r = '0;
    foreach (msg[i]) begin
      r = {r[15:0], msg[i]};
      if (r[16]) r ^= 17'h11021;
    end
    for (int i = 0; i < 16; i++) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r ^= 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic setup(input vec_t v);
    logic [3:0]  nib [1024];
    logic [15:0] crcs [4];
    for (int i = 0; i < 1024; i++) begin
      case (v.kind)
        0:       mem[i] = 8'h00;
        1:       mem[i] = ((i % 2) == 0 ? 8'hA5 : 8'h3C) + 8'(i / 2);
        default: mem[i] = 8'($urandom);
      endcase
    end
    exp_q.delete();
    exp_q.push_back(4'hF); exp_q.push_back(4'hF); exp_q.push_back(4'h0);
    for (int i = 0; i < 512; i++) begin
      nib[2*i]   = mem[i][7:4];
      nib[2*i+1] = mem[i][3:0];
    end
    for (int i = 0; i < 1024; i++) exp_q.push_back(nib[i]);
    for (int l = 0; l < 4; l++) begin
      bit msg [$];
      for (int j = 0; j < 1024; j++) msg.push_back(nib[j][l]);
      crcs[l] = crc_ref(msg);
    end
    for (int k = 15; k >= 0; k--) exp_q.push_back({crcs[3][k], crcs[2][k], crcs[1][k], crcs[0][k]});
    exp_q.push_back(4'hF);
    resp_q.delete();
    if (!v.no_tok) begin
      resp_q.push_back(1); resp_q.push_back(1); resp_q.push_back(0);
      resp_q.push_back(v.tok[2]); resp_q.push_back(v.tok[1]); resp_q.push_back(v.tok[0]);
      resp_q.push_back(1);
      for (int i = 0; i < v.busy; i++) resp_q.push_back(0);
    end
    card_tail = v.tail;
    addr      = '0;
    pulses    = 0;
    slots     = 0;
    dat_in    = 4'hF;
    cap_q.delete();
  endtask

  task automatic wait_status(input logic val, input int budget, input string name);
    int k = 0;
    while (status !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(status), 32'(val));
  endtask

  task automatic kick();
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_status(1'b1, 10, "start_seen");
    chk("err_clear_on_start", 32'(err), 0);
  endtask

  task automatic do_xfer(input vec_t v);
    int errs  = 0;
    int first = -1;
    setup(v);
    kick();
    if (v.retrig) begin
      int k = 0;
      while (pulses < 100 && k < 3000) begin @(negedge clk); k++; end
      en = 1'b0;
      repeat (4) @(negedge clk);
      en = 1'b1;
    end
    wait_status(1'b0, 20000, "xfer_done");
    chk("nextaddr_pulses", pulses, 512);
    chk("stream_len", cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      if (cap_q[i] !== exp_q[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    chk("stream_mism", errs, 0);
    if (errs != 0) $display("  first differing nibble %0d: got %h want %h", first, cap_q[first], exp_q[first]);
    chk("err", 32'(err), 32'(v.exp_err));
    chk("resp_slots", slots, v.exp_slots);
    chk("idle_pins", {oe, re, nxt, status}, 4'b0100);
    repeat (20) @(negedge clk);
    chk("err_hold", 32'(err), 32'(v.exp_err));
    dat_in = 4'hF;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    logic [2:0] t;
    vec_t v;
    tbl[0] = '{0, 0, 3'b010, 10, 1, 0, 2'b00, 18};
    tbl[1] = '{1, 0, 3'b010, 10, 1, 0, 2'b00, 18};
    tbl[2] = '{2, 0, 3'b101, 0,  1, 0, 2'b01, 6};
    b = $urandom_range(0, 20);
    tbl[3] = '{2, 0, 3'b010, b,  1, 0, 2'b00, 8 + b};
    tbl[4] = '{0, 1, 3'b000, 0,  1, 0, 2'b10, 16};
    tbl[5] = '{2, 0, 3'b010, 0,  0, 0, 2'b10, 108};
    b = $urandom_range(0, 20);
    tbl[6] = '{2, 0, 3'b010, b,  1, 1, 2'b00, 8 + b};
    b = $urandom_range(0, 20);
    t = 3'($urandom_range(0, 7));
    tbl[7] = '{2, 0, t, b, 1, 0, (t == 3'b010) ? 2'b00 : 2'b01, (t == 3'b010) ? 8 + b : 6};

    rst_n   = 1'b0;
    en      = 1'b0;
    dat_in  = 4'hF;
    addr    = '0;
    sd_prev = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_pins", {oe, re, nxt, status, dat_out, err}, 10'b0_1_0_0_1111_00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) do_xfer(tbl[i]);

    v = '{2, 0, 3'b010, 5, 1, 0, 2'b00, 13};
    setup(v);
    kick();
    begin
      int k = 0;
      int p;
      while (pulses < 200 && k < 5000) begin @(negedge clk); k++; end
      chk("abort_reached_byte200", 32'(pulses >= 200), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_pins", {oe, re, nxt, status, dat_out, err}, 10'b0_1_0_0_1111_00);
      p  = pulses;
      en = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_no_pulses", pulses, p);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    do_xfer(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sd_dma_wr.md
SD_DMA_WR -- requirements
Module: sd_dma_wr

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, bytes per block written.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16'hFFFF, maximum SD clocks of card busy.
REQ-003 SHALL have port CLK  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SD_DMA_EN  input  1  start request; a synchronised rising edge starts a block write.
REQ-006 SHALL have port SD_CLK  inout  1  card clock; driven while busy, else Z.
REQ-007 SHALL have port SD_DAT_OUT  output  4  data nibble driven to the card.
REQ-008 SHALL have port SD_DAT_OE  output  1  1 = SD_DAT lines driven by this block.
REQ-009 SHALL have port SD_DAT_IN  input  4  card data lines; only bit 0 is used.
REQ-010 SHALL have port SD_DMA_SRAM_DATA  input  8  SRAM read data at the current external address.
REQ-011 SHALL have port SD_DMA_SRAM_RE  output  1  SRAM read enable, active-low.
REQ-012 SHALL have port SD_DMA_NEXTADDR  output  1  one-CLK pulse; external address increments by 1.
REQ-013 SHALL have port SD_DMA_STATUS  output  1  1 while a transfer is in progress.
REQ-014 SHALL have port SD_DMA_ERR  output  2  [0] = CRC token not accepted, [1] = timeout; sticky until next start.

Function
REQ-015 SHALL pass SD_DMA_EN through a 2-FF synchroniser; start = sampled 01 on those stages, ignored unless state IDLE.
REQ-016 SHALL use a 2-bit phase counter, cleared at start, incrementing every CLK while not IDLE; SD_CLK = phase[1] registered (4 CLK per SD clock).
REQ-017 SHALL update SD_DAT_OUT only on CLK where phase==0 (SD_CLK low), so data is stable at the SD_CLK rising edge.
REQ-018 SHALL use states IDLE, PRE, START, DATA, CRC, END, TOKEN, BUSY; each state except IDLE lasts whole SD clocks.
REQ-019 IDLE: SD_DAT_OE=0, SD_DMA_STATUS=0, SD_CLK=Z, SD_DMA_SRAM_RE=1, SD_DMA_NEXTADDR=0.
REQ-020 PRE: 2 SD clocks, OE=1, DAT=4'hF, RE=0; byte 0 is captured from SD_DMA_SRAM_DATA into the prefetch register at the last phase==0 of PRE.
REQ-021 START: 1 SD clock, DAT=4'h0.
REQ-022 DATA: 2*BLOCK_BYTES SD clocks, high nibble then low nibble of each byte, bit 3 on DAT3.
REQ-023 At each high-nibble output the prefetch byte SHALL move to the shift register and NEXTADDR SHALL pulse once; the prefetch register SHALL capture SRAM data at the following phase==0 (4 CLK later).
REQ-024 Exactly BLOCK_BYTES NEXTADDR pulses SHALL occur per transfer; the caller presets the address to byte 0.
REQ-025 Four independent CRC16 registers (x^16+x^12+x^5+1, init 0) SHALL each accumulate their DAT line over DATA only.
REQ-026 CRC: 16 SD clocks, each line outputs its CRC MSB first.
REQ-027 END: 1 SD clock, DAT=4'hF; then OE=0 and RE=1.
REQ-028 TOKEN: DAT_IN[0] sampled at phase==2; the first 0 within 16 SD clocks SHALL be followed by 3 status bits; 3'b010 = accepted, otherwise set ERR[0]; no start bit sets ERR[1]; either error goes to IDLE.
REQ-029 BUSY: wait until DAT_IN[0]==1 at a phase==2 sample, then IDLE; more than BUSY_TIMEOUT SD clocks SHALL set ERR[1] and go to IDLE.
REQ-030 The start edge SHALL clear ERR; ERR SHALL hold its value in IDLE.
REQ-031 Counters SHALL be sized to hold 2*BLOCK_BYTES and BUSY_TIMEOUT without wrap.

Reset
REQ-032 RST_N low SHALL immediately force IDLE, with phase, counters, CRCs, ERR, synchroniser and data registers at 0, SD_DAT_OUT=4'hF and the REQ-019 output values.
REQ-033 Reset mid-transfer SHALL abort with no further NEXTADDR pulses; a new start is accepted after RST_N rises.

Verification
REQ-034 Start with SRAM model all 8'h00, card model returns token 0-010-1 and busy for 10 SD clocks -> 512 NEXTADDR pulses, 1024 DATA nibbles 0, CRC nibbles all 0, STATUS falls after busy, ERR=0.
REQ-035 SRAM bytes 8'hA5, 8'h3C, ... -> DAT sequence F,F,0,A,5,3,C,... with prefetch never stale; per-line CRCs match the software model.
REQ-036 Card returns token status 3'b101 -> ERR=2'b01, IDLE, OE=0, SD_CLK=Z.
REQ-037 Card holds DAT0 high after END for 16 SD clocks -> ERR=2'b10; with BUSY_TIMEOUT=100 and DAT0 held low -> ERR=2'b10 after 101 SD clocks.
REQ-038 RST_N low at byte 200 -> all outputs at reset values at once; a following start transfers a full block normally.
REQ-039 A second SD_DMA_EN rising edge during DATA -> ignored, pulse count stays 512.
